// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterative multi-cycle shifter (LSL/LSR/ASR/ROR) with valid/ready handshakes
// Shifts STEP bit positions per cycle and reports Z, N and Cout with the final result.
module shift_sequencer #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] C,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] B,
  output logic        Z,
  output logic        N,
  output logic        Cout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;
  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [1:0]  op_q, op_d;
  logic [5:0]  rem_q, rem_d;
  logic        z_q, z_d, n_q, n_d, cout_q, cout_d;

  logic [5:0]  n_eff;
  logic [5:0]  k;
  logic [31:0] shifted;
  logic        shout;

  // Rotates wrap modulo 32; linear shifts saturate at 32, where the result is fully determined.
  always_comb begin
    if (op == OP_ROR) begin
      n_eff = {1'b0, C[4:0]};
    end else if (C > 32'd32) begin
      n_eff = 6'd32;
    end else begin
      n_eff = C[5:0];
    end
  end

  always_comb begin
    k       = (rem_q < STEP_W) ? rem_q : STEP_W;
    shifted = work_q;
    shout   = 1'b0;
    case (op_q)
      OP_LSL: begin
        shifted = work_q << k;
        shout   = work_q[5'(6'd32 - k)];
      end
      OP_LSR: begin
        shifted = work_q >> k;
        shout   = work_q[5'(k - 6'd1)];
      end
      OP_ASR: begin
        shifted = 32'($signed(work_q) >>> k);
        shout   = work_q[5'(k - 6'd1)];
      end
      default: begin
        // The bit leaving at bit 0 on the last step lands in bit 31, so it doubles as Cout.
        shifted = (work_q >> k) | (work_q << (6'd32 - k));
        shout   = work_q[5'(k - 6'd1)];
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    op_d      = op_q;
    rem_d     = rem_q;
    z_d       = z_q;
    n_d       = n_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          work_d = A;
          op_d   = op;
          rem_d  = n_eff;
          cout_d = 1'b0;
          if (n_eff == 6'd0) begin
            state_d = DONE;
            z_d     = (A == 32'd0);
            n_d     = A[31];
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - k;
        cout_d = shout;
        if (rem_q == k) begin
          state_d = DONE;
          z_d     = (shifted == 32'd0);
          n_d     = shifted[31];
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= 32'd0;
      op_q    <= 2'b00;
      rem_q   <= 6'd0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      z_q     <= z_d;
      n_q     <= n_d;
      cout_q  <= cout_d;
    end
  end

  assign B    = work_q;
  assign Z    = z_q;
  assign N    = n_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed bench for shift_sequencer across STEP = 1, 2, 4, 8
module tb_shift_sequencer;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  typedef struct {
    int          idx;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] c;
    logic [31:0] b;
    logic        z;
    logic        n;
    logic        cout;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid_r  [4];
  logic        out_ready_r [4];
  logic [1:0]  op_r        [4];
  logic [31:0] a_r         [4];
  logic [31:0] c_r         [4];
  logic        in_ready_w  [4];
  logic        out_valid_w [4];
  logic [31:0] b_w         [4];
  logic        z_w         [4];
  logic        n_w         [4];
  logic        cout_w      [4];
  logic        busy_w      [4];

  int passed;
  int total;
  vec_t vecs [12];

  // Instance g runs with STEP = 2**g.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    shift_sequencer #(.STEP(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid_r[g]),
      .in_ready (in_ready_w[g]),
      .op       (op_r[g]),
      .A        (a_r[g]),
      .C        (c_r[g]),
      .out_valid(out_valid_w[g]),
      .out_ready(out_ready_r[g]),
      .B        (b_w[g]),
      .Z        (z_w[g]),
      .N        (n_w[g]),
      .Cout     (cout_w[g]),
      .busy     (busy_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    int    cyc;
    string nm;
    v  = vecs[i];
    nm = $sformatf("v%0d", i);
    @(negedge clk);
    chk({nm, "_ready_before"}, 32'(in_ready_w[v.idx]), 32'd1);
    op_r[v.idx]       = v.op;
    a_r[v.idx]        = v.a;
    c_r[v.idx]        = v.c;
    in_valid_r[v.idx] = 1'b1;
    @(negedge clk);
    in_valid_r[v.idx] = 1'b0;
    cyc = 1;
    while (!out_valid_w[v.idx] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(v.lat));
    chk({nm, "_B"}, b_w[v.idx], v.b);
    chk({nm, "_Z"}, 32'(z_w[v.idx]), 32'(v.z));
    chk({nm, "_N"}, 32'(n_w[v.idx]), 32'(v.n));
    chk({nm, "_Cout"}, 32'(cout_w[v.idx]), 32'(v.cout));
    @(negedge clk);
    chk({nm, "_idle_after"}, {30'd0, in_ready_w[v.idx], busy_w[v.idx]}, 32'b10);
  endtask

  initial begin
    int stray;
    int nacc;
    int nres;
    int acc_cyc [2];
    logic [31:0] bb_cout [2];

    passed = 0;
    total  = 0;
    vecs[0]  = '{0, ASR, 32'h80000000, 32'd4,          32'hF8000000, 1'b0, 1'b1, 1'b0, 5};
    vecs[1]  = '{2, LSR, 32'h0000000F, 32'd40,         32'h00000000, 1'b1, 1'b0, 1'b0, 9};
    vecs[2]  = '{1, ROR, 32'h00000001, 32'd33,         32'h80000000, 1'b0, 1'b1, 1'b1, 2};
    vecs[3]  = '{3, LSL, 32'hFFFFFFFF, 32'd0,          32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[4]  = '{3, LSL, 32'h00000001, 32'd32,         32'h00000000, 1'b1, 1'b0, 1'b1, 5};
    vecs[5]  = '{3, ASR, 32'h80000001, 32'hFFFFFFFF,   32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 5};
    vecs[6]  = '{2, ROR, 32'h12345678, 32'd8,          32'h78123456, 1'b0, 1'b0, 1'b0, 3};
    vecs[7]  = '{1, LSR, 32'h80000004, 32'd3,          32'h10000000, 1'b0, 1'b0, 1'b1, 3};
    vecs[8]  = '{2, LSL, 32'h0000000F, 32'd29,         32'hE0000000, 1'b0, 1'b1, 1'b1, 9};
    vecs[9]  = '{0, ROR, 32'h00000003, 32'd32,         32'h00000003, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{1, ASR, 32'h40000000, 32'd31,         32'h00000000, 1'b1, 1'b0, 1'b1, 17};
    vecs[11] = '{3, ROR, 32'h80000001, 32'd31,         32'h00000003, 1'b0, 1'b0, 1'b0, 5};

    for (int g = 0; g < 4; g++) begin
      in_valid_r[g]  = 1'b0;
      out_ready_r[g] = 1'b1;
      op_r[g]        = 2'b00;
      a_r[g]         = 32'd0;
      c_r[g]         = 32'd0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g += 3) begin
      chk($sformatf("reset_ctrl_%0d", g),
          {28'd0, in_ready_w[g], out_valid_w[g], busy_w[g], 1'b0}, 32'b1000);
      chk($sformatf("reset_data_%0d", g), b_w[g], 32'd0);
      chk($sformatf("reset_flags_%0d", g), {29'd0, z_w[g], n_w[g], cout_w[g]}, 32'd0);
    end
    rst = 1'b0;

    // Reset lands in the second SHIFT cycle of an ASR on STEP=1.
    @(negedge clk);
    op_r[0] = ASR; a_r[0] = 32'h80000000; c_r[0] = 32'd4; in_valid_r[0] = 1'b1;
    @(negedge clk);
    in_valid_r[0] = 1'b0;
    @(negedge clk);
    chk("midrst_busy_before", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ctrl", {29'd0, in_ready_w[0], out_valid_w[0], busy_w[0]}, 32'b100);
    chk("midrst_B", b_w[0], 32'd0);
    chk("midrst_flags", {29'd0, z_w[0], n_w[0], cout_w[0]}, 32'd0);
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid_w[0]) stray++;
    end
    chk("midrst_no_out_valid", 32'(stray), 32'd0);

    for (int i = 0; i < 12; i++) run_vec(i);

    // n=0 result held under back-pressure; a second request must not be taken.
    out_ready_r[3] = 1'b0;
    @(negedge clk);
    op_r[3] = LSL; a_r[3] = 32'hFFFFFFFF; c_r[3] = 32'd0; in_valid_r[3] = 1'b1;
    @(negedge clk);
    a_r[3] = 32'h12345678; c_r[3] = 32'd4;
    chk("hold_first_valid", 32'(out_valid_w[3]), 32'd1);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk($sformatf("hold_B_%0d", j), b_w[3], 32'hFFFFFFFF);
      chk($sformatf("hold_ctl_%0d", j),
          {26'd0, in_ready_w[3], out_valid_w[3], z_w[3], n_w[3], cout_w[3], busy_w[3]}, 32'b010101);
    end
    out_ready_r[3] = 1'b1;
    in_valid_r[3]  = 1'b0;
    @(negedge clk);
    chk("hold_release_ctl", {29'd0, in_ready_w[3], out_valid_w[3], busy_w[3]}, 32'b100);
    chk("hold_release_B", b_w[3], 32'hFFFFFFFF);

    // Back-to-back on STEP=1 with out_ready tied high.
    bb_cout[0] = 32'd0;
    bb_cout[1] = 32'd1;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    nacc = 0;
    nres = 0;
    @(negedge clk);
    op_r[0] = LSL; a_r[0] = 32'h00000001; c_r[0] = 32'd31; in_valid_r[0] = 1'b1;
    for (int cyc = 0; cyc < 90; cyc++) begin
      logic took;
      took = 1'b0;
      if (out_valid_w[0]) begin
        if (nres < 2) begin
          chk($sformatf("b2b_B_%0d", nres), b_w[0], 32'h80000000);
          chk($sformatf("b2b_N_%0d", nres), 32'(n_w[0]), 32'd1);
          chk($sformatf("b2b_Cout_%0d", nres), 32'(cout_w[0]), bb_cout[nres]);
        end
        nres++;
      end
      if (in_ready_w[0] && in_valid_r[0]) begin
        if (nacc < 2) acc_cyc[nacc] = cyc;
        nacc++;
        took = 1'b1;
      end
      @(posedge clk);
      #1;
      if (took) begin
        if (nacc == 1) a_r[0] = 32'h00000003;
        else in_valid_r[0] = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_results", 32'(nres), 32'd2);
    chk("b2b_accepts", 32'(nacc), 32'd2);
    chk("b2b_interval", 32'(acc_cyc[1] - acc_cyc[0]), 32'd33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
